// File: rtl/prefetch_fetch_if.sv
// -----------------------------------------------------------------------------
// prefetch_fetch_if
//   Bundles the fetch-stage bus: the redirect request, the instruction-memory
//   read port and the decode-side output handshake.
//
//   modport master : the fetch stage (drives imem_ren/imem_raddr, out_*, occupancy)
//   modport slave  : the environment (drives redirect, imem_rdata, out_ready)
//
//   Output handshake: an instruction transfers to DEC in any cycle where
//   out_valid and out_ready are both 1 at the rising clock edge. While
//   out_valid=1 and out_ready=0, out_pc/out_instr hold their values. out_valid
//   never depends on out_ready; out_pc/out_instr are don't-care while
//   out_valid=0.
// -----------------------------------------------------------------------------
interface prefetch_fetch_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   imem_ren;
  logic [PC_WIDTH-1:0]    imem_raddr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    input  redirect, redirect_pc, imem_rdata, out_ready,
    output imem_ren, imem_raddr, out_valid, out_pc, out_instr, occupancy
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, out_ready,
    input  imem_ren, imem_raddr, out_valid, out_pc, out_instr, occupancy
  );
endinterface

// File: rtl/prefetch_fetch.sv
// -----------------------------------------------------------------------------
// prefetch_fetch
//   Instruction fetch stage with a prefetch queue. Holds the fetch PC, issues
//   reads to a synchronous instruction memory (data returns one cycle after
//   imem_ren), queues each returned instruction tagged with its PC, and
//   presents the queue head to decode. A redirect flushes the queue, drops the
//   read in flight and restarts fetch at redirect_pc.
//
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : prefetch_fetch_if.master (redirect, imem read port, out_* handshake,
//            occupancy)
// -----------------------------------------------------------------------------
module prefetch_fetch #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int PC_STEP     = 1,
  parameter int RESET_PC    = 0
) (
  input logic              clk,
  input logic              rst,
  prefetch_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [PC_WIDTH-1:0] STEP_C  = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] RST_PC  = PC_WIDTH'(RESET_PC);
  localparam logic [CW:0]         DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [AW-1:0]       PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0]    r_fetch_pc;
  logic [PC_WIDTH-1:0]    r_tag;       // PC of the read currently in flight
  logic                   r_inflight;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [PC_WIDTH-1:0]    r_pc_q    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr_q [FIFO_DEPTH];

  logic        w_pop;
  logic        w_push;
  logic [CW:0] w_committed;
  logic        w_room;
  logic        w_issue;

  assign w_pop  = (r_count != '0) && bus.out_ready;
  // Returning data is thrown away in the cycle a redirect arrives.
  assign w_push = r_inflight && !bus.redirect;

  // Slots already spoken for after this cycle: queued + in flight - leaving.
  // A new read is issued only when a slot is still free, so the data always
  // has somewhere to land and the queue cannot overflow. Counting this
  // cycle's pop as a freed slot keeps a full-rate stream with no bubbles.
  assign w_committed = {1'b0, r_count}
                     + {{CW{1'b0}}, r_inflight}
                     - {{CW{1'b0}}, w_pop};
  assign w_room      = w_committed < DEPTH_C;
  assign w_issue     = !rst && !bus.redirect && w_room;

  assign bus.imem_ren   = w_issue;
  assign bus.imem_raddr = r_fetch_pc;
  assign bus.out_valid  = (r_count != '0);
  assign bus.out_pc     = r_pc_q[r_rd_ptr];
  assign bus.out_instr  = r_instr_q[r_rd_ptr];
  assign bus.occupancy  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RST_PC;
      r_tag      <= RST_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (bus.redirect) begin
      // A pop in this cycle has already been taken by decode; the remaining
      // entries and the in-flight read belong to the wrong path.
      r_fetch_pc <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag      <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + STEP_C;  // wraps modulo 2^PC_WIDTH
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]    <= r_tag;
      r_instr_q[r_wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule
